// File: rtl/fetch_queue_stage_pkg.sv
// Shared definitions for the fetch queue stage: default vectors, fetch FSM
// encodings and the {PC, Instr} queue entry layout.
package fetch_queue_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;
    localparam int          ENTRY_W      = 64;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DS_WAIT = 2'd1,
        HALT_DS = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_queue_stage_if.sv
// Handshake bundle of the fetch queue stage: instruction memory side,
// decode side and the redirect inputs.
interface fetch_queue_stage_if;
    logic        IM_Req;
    logic [31:0] IM_Addr;
    logic        IM_Rdy;
    logic [31:0] IM_Instr;
    logic        F_Valid;
    logic        D_Ready;
    logic [31:0] F_Instr;
    logic [31:0] F_PC;
    logic [31:0] F_PCplus4;
    logic        E_IntReq;
    logic        D_isEret;
    logic [31:0] E_EPC;
    logic        D_isBranch;
    logic [31:0] D_NPC;

    modport master (
        output IM_Req, IM_Addr, F_Valid, F_Instr, F_PC, F_PCplus4,
        input  IM_Rdy, IM_Instr, D_Ready, E_IntReq, D_isEret, E_EPC,
               D_isBranch, D_NPC
    );

    modport slave (
        input  IM_Req, IM_Addr, F_Valid, F_Instr, F_PC, F_PCplus4,
        output IM_Rdy, IM_Instr, D_Ready, E_IntReq, D_isEret, E_EPC,
               D_isBranch, D_NPC
    );
endinterface

// File: rtl/fetch_queue_stage_fq_ram.sv
// DEPTH x 64 register-file queue with push/pop, full flush and a truncate
// operation that keeps only the entry after the head.
module fq_ram
    import fetch_queue_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     flush,
    input  logic                     trunc,
    input  logic                     push,
    input  logic                     pop,
    input  fq_entry_t                wdata,
    output fq_entry_t                rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;

    always_ff @(posedge Clk) begin
        if (Reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (trunc) begin
            // head is consumed, the entry after it survives as the delay slot
            rd_ptr <= rd_ptr + AW'(1);
            wr_ptr <= rd_ptr + AW'(2);
            count  <= (AW+1)'(1);
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = fq_entry_t'(mem[rd_ptr]);

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch queue stage: PC, redirect/delay-slot FSM and the fq_ram queue.
// Optional performance counters are built when FQ_PERF_EN is defined.
//
// state   | meaning
// RUN     | normal sequential fetch
// DS_WAIT | branch taken with queue empty; next fetch is the delay slot,
//         | after which the PC jumps to the latched target
// HALT_DS | reserved, never entered, treated as RUN
module fetch_queue_stage
    import fetch_queue_stage_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
    input  logic                Clk,
    input  logic                Reset,
    fetch_queue_stage_if.master bus
`ifdef FQ_PERF_EN
    ,
    output logic [31:0]         Perf_StallCyc,
    output logic [31:0]         Perf_FlushCnt
`endif
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    fetch_state_t state, state_nx;
    logic [31:0]  pc, pc_nx;
    logic [31:0]  target, target_nx;
    logic [AW:0]  count;
    fq_entry_t    head;
    logic         f_valid, pop, im_req, fetch_ok, push, flush, trunc, branch;

    assign f_valid  = (count != '0);
    assign pop      = f_valid & bus.D_Ready;
    assign im_req   = ~Reset & (state != HALT_DS) & ((count < DEPTH_C) | pop);
    assign flush    = bus.E_IntReq | bus.D_isEret;
    assign fetch_ok = im_req & bus.IM_Rdy & ~flush;
    assign branch   = bus.D_isBranch & pop & ~flush;
    assign trunc    = branch & (count >= (AW+1)'(2));
    assign push     = fetch_ok & ~trunc;

    fq_ram #(.DEPTH(DEPTH)) u_ram (
        .Clk   (Clk),
        .Reset (Reset),
        .flush (flush),
        .trunc (trunc),
        .push  (push),
        .pop   (pop & ~flush & ~trunc),
        .wdata ({pc, bus.IM_Instr}),
        .rdata (head),
        .count (count)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= RUN;
            pc     <= RESET_PC;
            target <= '0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            target <= target_nx;
        end
    end

    always_comb begin
        state_nx  = (state == HALT_DS) ? RUN : state;
        pc_nx     = pc;
        target_nx = target;
        if (bus.E_IntReq) begin
            pc_nx    = EXC_VEC;
            state_nx = RUN;
        end else if (bus.D_isEret) begin
            pc_nx    = bus.E_EPC;
            state_nx = RUN;
        end else if (branch) begin
            state_nx = RUN;
            if (trunc || push) begin
                pc_nx = bus.D_NPC;
            end else begin
                // delay slot not fetched yet: remember where to go afterwards
                target_nx = bus.D_NPC;
                state_nx  = DS_WAIT;
            end
        end else if (push) begin
            if (state == DS_WAIT) begin
                pc_nx    = target;
                state_nx = RUN;
            end else begin
                pc_nx = pc_plus4(pc);
            end
        end
    end

    assign bus.IM_Req    = im_req;
    assign bus.IM_Addr   = pc;
    assign bus.F_Valid   = f_valid;
    assign bus.F_PC      = head.pc;
    assign bus.F_Instr   = head.instr;
    assign bus.F_PCplus4 = pc_plus4(head.pc);

`ifdef FQ_PERF_EN
    logic [AW:0]  discard;
    logic [32:0]  flush_sum;

    always_comb begin
        discard = '0;
        if (flush)      discard = count;
        else if (trunc) discard = count - (AW+1)'(2);
    end

    assign flush_sum = {1'b0, Perf_FlushCnt} + 33'(discard);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Perf_StallCyc <= '0;
            Perf_FlushCnt <= '0;
        end else begin
            if (!f_valid && Perf_StallCyc != 32'hFFFF_FFFF)
                Perf_StallCyc <= Perf_StallCyc + 32'd1;
            Perf_FlushCnt <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
        end
    end
`endif

endmodule
